// File: rtl/nios_cpu_intern_pio_irq.sv
// Avalon-MM input PIO with optional synchroniser, per-bit edge capture (W1C),
// interrupt mask and a registered IRQ output.
module nios_cpu_intern_pio_irq #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [1:0] AddrData = 2'd0;
  localparam logic [1:0] AddrMask = 2'd2;
  localparam logic [1:0] AddrEdge = 2'd3;

  localparam int unsigned WarmCycles = SYNC_STAGES + 1;

  logic [DATA_WIDTH-1:0] v;
  logic [DATA_WIDTH-1:0] v_d_q;
  logic [2:0]            warm_q, warm_d;
  logic                  warm_done;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic [DATA_WIDTH-1:0] irq_src;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic                  wr_en;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign v = in_port;
    end else begin : g_sync
      localparam int unsigned ChainW = SYNC_STAGES * DATA_WIDTH;
      logic [ChainW-1:0] sync_q, sync_d;

      // Stage 0 sits in the low bits; the oldest sample lives at the top.
      assign sync_d = ChainW'({sync_q, in_port});
      assign v      = sync_q[ChainW-1 -: DATA_WIDTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end
    end

    if (DATA_WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:DATA_WIDTH];
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;

  // Edge detection stays off until v and v_d both carry post-reset samples,
  // so a level already present at reset release is not seen as an edge.
  always_comb begin
    warm_done = (warm_q == 3'(WarmCycles));
    warm_d    = warm_done ? warm_q : warm_q + 3'd1;
  end

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_det = v & ~v_d_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~v & v_d_q;
    end else begin
      edge_det = v ^ v_d_q;
    end
    if (!warm_done) begin
      edge_det = '0;
    end
  end

  // A new edge overrides a same-cycle clear so no event is lost.
  always_comb begin
    clr_bits  = (wr_en && address == AddrEdge) ? writedata[DATA_WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~clr_bits) | edge_det;
    mask_d    = (wr_en && address == AddrMask) ? writedata[DATA_WIDTH-1:0] : mask_q;
  end

  always_comb begin
    rdata_d = '0;
    unique case (address)
      AddrData: rdata_d[DATA_WIDTH-1:0] = v;
      AddrMask: rdata_d[DATA_WIDTH-1:0] = mask_q;
      AddrEdge: rdata_d[DATA_WIDTH-1:0] = edgecap_q;
      default:  rdata_d = '0;
    endcase
  end

  always_comb begin
    irq_src = (IRQ_MODE == 1) ? v : edgecap_q;
    irq_d   = |(irq_src & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_d_q     <= '0;
      warm_q    <= '0;
      mask_q    <= '0;
      edgecap_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      v_d_q     <= v;
      warm_q    <= warm_d;
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_cpu_intern_pio_irq.sv
// Bench for the IRQ input PIO: three configurations on a shared bus, checked every
// cycle against a behavioural model plus hand-computed directed expectations.
module tb_nios_cpu_intern_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  pa, pb;
  logic [31:0] pc;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;
  logic        chk_en;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // a: rising edge, edge IRQ; b: level IRQ; c: 32 bits, no sync, any edge
  nios_cpu_intern_pio_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pa), .readdata(rd_a), .irq(irq_a)
  );

  nios_cpu_intern_pio_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pb), .readdata(rd_b), .irq(irq_b)
  );

  nios_cpu_intern_pio_irq #(
    .DATA_WIDTH(32), .SYNC_STAGES(0), .EDGE_TYPE(2), .IRQ_MODE(0)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pc), .readdata(rd_c), .irq(irq_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: v seen at an edge is the pin value sampled s edges earlier.
  logic [31:0] m_hist [3][4];
  logic [31:0] m_vprev [3];
  logic [31:0] m_ec [3];
  logic [31:0] m_mask [3];
  logic [31:0] e_rd [3];
  logic        e_irq [3];
  int          m_cnt [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) m_hist[k][i] = '0;
      m_vprev[k] = '0;
      m_ec[k]    = '0;
      m_mask[k]  = '0;
      e_rd[k]    = '0;
      e_irq[k]   = 1'b0;
      m_cnt[k]   = 0;
    end
  endtask

  task automatic model_step(input int k, input int w, input int s, input int et, input int im,
                            input logic [31:0] pin);
    logic [31:0] wm, vin, edges, clr;
    wm  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    vin = (s == 0) ? (pin & wm) : m_hist[k][s-1];
    case (address)
      2'd0:    e_rd[k] = vin;
      2'd2:    e_rd[k] = m_mask[k];
      2'd3:    e_rd[k] = m_ec[k];
      default: e_rd[k] = '0;
    endcase
    e_irq[k] = ((((im == 1) ? vin : m_ec[k]) & m_mask[k]) != 32'd0);
    edges = '0;
    if (m_cnt[k] > s) begin
      case (et)
        0:       edges = vin & ~m_vprev[k];
        1:       edges = ~vin & m_vprev[k];
        default: edges = vin ^ m_vprev[k];
      endcase
    end
    edges = edges & wm;
    clr = (chipselect && !write_n && address == 2'd3) ? writedata : 32'd0;
    m_ec[k] = (m_ec[k] & ~clr) | edges;
    if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata & wm;
    for (int i = 3; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
    m_hist[k][0] = pin & wm;
    m_vprev[k] = vin;
    if (m_cnt[k] < 100) m_cnt[k]++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        model_step(0, 8, 2, 0, 0, {24'd0, pa});
        model_step(1, 8, 2, 0, 1, {24'd0, pb});
        model_step(2, 32, 0, 2, 0, pc);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_rd_a", rd_a, e_rd[0]);
        check("model_irq_a", 32'(irq_a), 32'(e_irq[0]));
        check("model_rd_b", rd_b, e_rd[1]);
        check("model_irq_b", 32'(irq_b), 32'(e_irq[1]));
        check("model_rd_c", rd_c, e_rd[2]);
        check("model_irq_c", 32'(irq_c), 32'(e_irq[2]));
      end
    end
  end

  // Called on a negedge; strobe is seen by exactly one rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    chk_en     = 1'b0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    pa         = 8'hA5;
    pb         = 8'h00;
    pc         = 32'h0;
    cycles(3);
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_irq_a", 32'(irq_a), 32'h0);

    chk_en  = 1'b1;
    reset_n = 1'b1;
    cycles(4);
    check("data_a5", rd_a, 32'h0000_00A5);
    address = 2'd3;
    cycles(1);
    check("ec_after_warmup", rd_a, 32'h0);
    check("irq_after_warmup", 32'(irq_a), 32'h0);

    // Rising capture on bit0 with IRQ
    bus_write(2'd2, 32'h01);
    address = 2'd3;
    pa = 8'hA4;
    cycles(4);
    pa = 8'hA5;
    cycles(3);
    check("irq_a_not_yet", 32'(irq_a), 32'h0);
    cycles(1);
    check("irq_a_rise", 32'(irq_a), 32'h1);
    check("ec_a_rise", rd_a, 32'h1);

    // W1C clear, then write-0 keeps the bit
    bus_write(2'd3, 32'h01);
    address = 2'd3;
    cycles(1);
    check("irq_a_cleared", 32'(irq_a), 32'h0);
    check("ec_a_cleared", rd_a, 32'h0);
    pa = 8'hA4;
    cycles(2);
    pa = 8'hA5;
    cycles(4);
    bus_write(2'd3, 32'h00);
    address = 2'd3;
    cycles(2);
    check("ec_a_w0_holds", rd_a, 32'h1);
    bus_write(2'd3, 32'hFFFF_FFFF);

    // Bit2 edge detected on the same edge as its clear
    address = 2'd3;
    pa = 8'hA1;
    cycles(4);
    pa = 8'hA5;
    cycles(2);
    bus_write(2'd3, 32'h04);
    address = 2'd3;
    cycles(2);
    check("set_wins", rd_a, 32'h4);

    // Level IRQ on instance b
    bus_write(2'd2, 32'h80);
    pb = 8'h80;
    cycles(2);
    check("irq_b_not_yet", 32'(irq_b), 32'h0);
    cycles(1);
    check("irq_b_level_hi", 32'(irq_b), 32'h1);
    pb = 8'h00;
    cycles(2);
    check("irq_b_still_hi", 32'(irq_b), 32'h1);
    cycles(1);
    check("irq_b_level_lo", 32'(irq_b), 32'h0);
    bus_write(2'd2, 32'h00);
    pb = 8'h80;
    cycles(5);
    check("irq_b_masked", 32'(irq_b), 32'h0);

    // 32-bit, no sync, any edge: bit31 falling
    bus_write(2'd2, 32'h8000_0000);
    pc = 32'h8000_0000;
    cycles(2);
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    pc = 32'h0;
    cycles(2);
    check("ec_c_fall31", rd_c, 32'h8000_0000);
    check("irq_c_fall31", 32'(irq_c), 32'h1);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_rd_c", rd_c, 32'h0);
    check("async_rst_irq_c", 32'(irq_c), 32'h0);
    check("async_rst_rd_a", rd_a, 32'h0);
    check("async_rst_irq_b", 32'(irq_b), 32'h0);
    @(negedge clk);
    address = 2'd2;
    reset_n = 1'b1;
    cycles(2);
    check("mask_c_after_rst", rd_c, 32'h0);
    address = 2'd3;
    cycles(4);
    check("ec_a_after_rst", rd_a, 32'h0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios_cpu_intern_pio_irq.md
Name: nios_cpu_intern_pio_irq

Overview:
Parametrised Avalon-MM slave input PIO for the Nios CPU subsystem. It supports configurable width and a configurable input synchroniser. It adds per-bit edge capture with write-1-to-clear, an interrupt mask register and a registered IRQ output. It replaces the fixed 8-bit read-only input PIO wherever firmware needs to be interrupted by status pins.

Parameters:
DATA_WIDTH, 8, number of input bits; legal range 1..32.
SYNC_STAGES, 2, flip-flop stages on in_port before use; legal 0..3; 0 = in_port used directly.
EDGE_TYPE, 0, capture condition: 0 = rising, 1 = falling, 2 = any edge.
IRQ_MODE, 0, IRQ source: 0 = edge (edgecapture & irqmask), 1 = level (synchronised input & irqmask).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
address  in  2  Avalon word address.
chipselect  in  1  Avalon chip select.
write_n  in  1  Avalon write strobe, active low.
writedata  in  32  Avalon write data.
in_port  in  DATA_WIDTH  external input pins, asynchronous to clk.
readdata  out  32  registered Avalon read data.
irq  out  1  registered interrupt request, active high.

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk. While reset_n=0, all sync stages, v_d, irqmask, edgecapture, readdata, irq and the warm-up counter are 0.
- Synchroniser: SYNC_STAGES registers in series. v = output of the last stage, or in_port when SYNC_STAGES=0. v_d = v registered one cycle.
- Edge detect:
  - rise = v & ~v_d; fall = ~v & v_d; any = v ^ v_d, selected by EDGE_TYPE.
  - Warm-up counter suppresses edge detection for the first SYNC_STAGES+1 rising clk edges after reset deassertion, so a level already present at reset release never sets edgecapture. Counter saturates; no further effect.
- Register map (word address; reads zero-extended, unused upper bits read 0):
  - 0 data: reads v. Writes ignored.
  - 1 reserved: reads 0. Writes ignored.
  - 2 irqmask: RW, bits [DATA_WIDTH-1:0]; upper writedata bits ignored.
  - 3 edgecapture: read returns captured bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Write strobe = chipselect & ~write_n, sampled on rising clk.
- Readdata is registered every clk from the current address, independent of chipselect (one-cycle read latency). It reflects register contents before any same-cycle update.
- Edgecapture update per bit each clk:
  - Edge detected: bit <= 1.
  - Else write-1 to that bit at address 3: bit <= 0.
  - Else hold.
  - Simultaneous edge and clear: set wins; the event is not lost.
- IRQ: irq <= |(src & irqmask) each clk, with src = edgecapture (IRQ_MODE 0) or v (IRQ_MODE 1). irq is one cycle behind the registers it depends on.
- Latency, SYNC_STAGES=2, rising mode: in_port bit rises before clk edge N.
  - v=1 at edge N+1.
  - edgecapture bit set at edge N+2.
  - irq=1 at edge N+3, if the bit is masked in.
- Pulses on in_port shorter than one clk period may be missed; this is not an error.
- Reset asserted mid-operation clears everything asynchronously and restarts warm-up.

Test Plan:
- Reset/read: DATA_WIDTH=8. Hold in_port=0xA5 through reset release, wait 4 clk, read addr 0 -> readdata=0x000000A5. Read addr 3 -> 0x00000000; irq stays 0.
- Rising capture + IRQ: write irqmask=0x01 to addr 2. Drive in_port bit0 0->1 before edge N -> edgecapture=0x01 at N+2, irq=1 at N+3. Read addr 3 -> 0x00000001.
- Clear: write 0x01 to addr 3 -> edgecapture=0x00 next edge, irq=0 one edge later. Writing 0x00 to addr 3 with bit set -> bit stays 1.
- Set-wins collision: schedule a bit2 rising edge detect on the same clk as a write 0x04 to addr 3 -> edgecapture bit2 remains 1.
- Masking/level mode: IRQ_MODE=1, irqmask=0x80. in_port=0x80 -> irq=1 after SYNC_STAGES+1 edges; in_port=0x00 -> irq=0 after the same latency. irqmask=0x00 -> irq stays 0 regardless of input.
- Parameter sweep: DATA_WIDTH=32, SYNC_STAGES=0, EDGE_TYPE=2. Toggle bit31 1->0 -> edgecapture=0x80000000 one edge later. Assert reset_n=0 mid-sequence -> all registers and irq read 0 immediately.
